// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader FSM encoding, the word size in bytes and the checksum width.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    localparam int BOOT_BYTES_PER_WORD = 4;
    localparam int BOOT_CSUM_W         = 8;

endpackage

// File: rtl/word_assembler.sv
// Collects payload bytes little-endian into 32-bit words; o_word_valid is
// combinational on the accept of the last byte so the caller can register it.
module word_assembler
    import boot_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    // Only the first three bytes need storage; the fourth arrives on i_byte.
    logic [23:0] r_shreg;
    logic [1:0]  r_idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if (i_byte_valid) begin
            r_shreg <= {i_byte, r_shreg[23:8]};
            r_idx   <= r_idx + 2'd1;
        end
    end

    assign o_word_valid = i_byte_valid && (r_idx == 2'(BOOT_BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_shreg};

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: length header, payload words into imem, XOR checksum,
// then releases the core. Optional inter-byte timeout: `define BOOT_LOADER_TIMEOUT_EN.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output boot_state_t       dbg_state
);

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(1) << ADDR_W;

    boot_state_t            r_state;
    boot_state_t            w_next_state;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_word_cnt;
    logic [BOOT_CSUM_W-1:0] r_csum;

    logic                   w_accept;
    logic [LEN_W-1:0]       w_len_rx;
    logic [LEN_W-1:0]       w_word_cnt_inc;
    logic                   w_word_valid;
    logic [31:0]            w_word;
    logic                   w_tmo_hit;

    // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
    // rx_ready depends only on the state, never on rx_valid.
    assign rx_ready       = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                            (r_state == ST_DATA)   || (r_state == ST_CSUM);
    assign w_accept       = rx_valid && rx_ready;
    assign w_len_rx       = LEN_W'({rx_data, r_len[7:0]});
    assign w_word_cnt_inc = r_word_cnt + LEN_W'(1);
    assign dbg_state      = r_state;

    word_assembler u_word_assembler (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear      (r_state == ST_IDLE),
        .i_byte_valid (w_accept && (r_state == ST_DATA)),
        .i_byte       (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef BOOT_LOADER_TIMEOUT_EN
    logic [31:0] r_tmo;
    logic        w_tmo_run;

    // LEN_LO is excluded so the loader can wait forever for a host to start.
    assign w_tmo_run = (r_state == ST_LEN_HI) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_tmo_hit = w_tmo_run && !w_accept && (r_tmo == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (!w_tmo_run || w_accept) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 32'd1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   w_next_state = ST_LEN_LO;
            ST_LEN_LO: if (w_accept) w_next_state = ST_LEN_HI;
            ST_LEN_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_len_rx} > MAX_LEN) w_next_state = ST_ERROR;
                    else if (w_len_rx == '0)        w_next_state = ST_CSUM;
                    else                            w_next_state = ST_DATA;
                end
            end
            ST_DATA:   if (w_word_valid && (w_word_cnt_inc == r_len)) w_next_state = ST_CSUM;
            ST_CSUM: begin
                if (w_accept) w_next_state = (rx_data == r_csum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE, ST_ERROR: if (reload) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
        if (w_tmo_hit) w_next_state = ST_ERROR;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_csum     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            imem_we   <= 1'b0;
            // Status flags follow the next state so cpu_reset drops on the DONE entry edge.
            cpu_reset <= (w_next_state != ST_DONE);
            done      <= (w_next_state == ST_DONE);
            error     <= (w_next_state == ST_ERROR);
            case (r_state)
                ST_IDLE: begin
                    r_len      <= '0;
                    r_word_cnt <= '0;
                    r_csum     <= '0;
                end
                ST_LEN_LO: if (w_accept) r_len[7:0] <= rx_data;
                ST_LEN_HI: if (w_accept) r_len <= w_len_rx;
                ST_DATA: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ rx_data;
                        if (w_word_valid) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_word_cnt[ADDR_W-1:0];
                            imem_wdata <= w_word;
                            r_word_cnt <= w_word_cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream neighbour of the single-cycle core. Accepts a byte stream (UART/debug link, valid/ready), assembles little-endian 32-bit words and writes them into instruction memory through a write port.
- Holds the core in reset until a complete, checksum-verified image is loaded, then releases it.
- Sits between the byte receiver and the instruction memory, and drives the core's active-high reset.

Parameters:
- ADDR_W, 10, instruction memory word-address width; capacity is 2**ADDR_W words.
- LEN_W, 16, width of the image-length header field in words.
- TIMEOUT_CYC, 1000000, inter-byte timeout in clocks (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid && rx_ready.
- reload  in  1  one-cycle pulse; restarts loading from DONE or ERROR.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- cpu_reset  out  1  active-high reset to the processor.
- done  out  1  image loaded and verified.
- error  out  1  load failed (length overflow, checksum mismatch, timeout).

Behaviour:
- Async reset (reset_n=0) sets:
  - state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, done=0, error=0, byte counter=0, word counter=0, checksum=0.
- All other logic is synchronous to the rising edge of clock.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
- IDLE:
  - Lasts one cycle, then LEN_LO.
  - Clears counters, checksum and done/error; holds cpu_reset=1.
- rx_ready=1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in all other states.
- LEN_LO, LEN_HI:
  - Each accepted byte is the low/high byte of len (LEN_W bits, little-endian).
- After LEN_HI accept:
  - If len > 2**ADDR_W → ERROR.
  - Else if len == 0 → CSUM.
  - Else → DATA.
- DATA:
  - Bytes fill a 32-bit shift register little-endian (byte 0 → bits 7:0).
  - On the 4th byte accept, in the next cycle:
    - imem_we=1 for exactly one cycle.
    - imem_wdata = assembled word.
    - imem_addr = word counter, truncated to ADDR_W.
    - Word counter then increments.
  - When word counter reaches len on that write → CSUM.
  - Write latency: exactly 1 clock after the accepting edge of the 4th byte.
- Checksum:
  - 8-bit XOR of every data-payload byte; header bytes are excluded.
  - Updated on each accepted DATA byte.
- CSUM:
  - One byte accepted.
  - If it equals the running checksum → DONE, else → ERROR.
- DONE: done=1, cpu_reset=0, rx_ready=0; bytes are ignored.
- ERROR: error=1, cpu_reset=1, rx_ready=0.
- reload pulse:
  - In DONE or ERROR → IDLE, with cpu_reset=1 in the same edge.
  - Ignored in every other state.
- len == 2**ADDR_W is legal: last address is 2**ADDR_W-1, and imem_addr does not wrap before completion.
- rx_valid held low mid-word: the loader waits indefinitely (unless the optional feature is compiled in); partial word state is retained.
- reset_n asserted mid-load: immediate abort to reset values; memory contents already written are left as-is.
- cpu_reset is registered and glitch-free. It deasserts only on the DONE entry edge.

Optional Feature:
- Macro: BOOT_LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN_HI, DATA and CSUM, and clears on every accepted byte.
  - Reaching TIMEOUT_CYC-1 without a byte → ERROR.
  - LEN_LO (waiting for the first byte) never times out.
- Undefined: no counter, no timeout path; TIMEOUT_CYC is unused.

Decomposition:
- Shared package boot_pkg holds:
  - state enum type boot_state_t (7 states);
  - constant BOOT_BYTES_PER_WORD=4;
  - the XOR checksum width.
- One natural sub-module, word_assembler:
  - byte shift register plus 2-bit byte index;
  - emits word_valid with the 32-bit word;
  - clears on IDLE.
- The FSM, counters, checksum and timeout stay in the top.

Test Plan:
- Load len=2, words 0x00500093, 0x00A00113, checksum XOR of their 8 bytes:
  - imem writes (0,0x00500093) then (1,0x00A00113), each a one-cycle imem_we;
  - then done=1 and cpu_reset falls one cycle after the checksum byte.
- Same image with checksum byte XOR 0x01 → error=1, cpu_reset stays 1, no further imem_we; reload pulse → IDLE, and a correct reload succeeds.
- len=0 followed by checksum byte 0x00 → done=1 with zero imem writes.
- Length overflow and boundary, with ADDR_W=10:
  - len=1025 → ERROR right after the header, with no writes;
  - len=1024 → last write at address 1023.
- rx_valid toggled randomly (50% duty) during DATA → identical write sequence and data to the back-to-back case. Assert reset_n=0 after byte 6 → all outputs return to reset values asynchronously.
- With BOOT_BYTES_PER_WORD... with BOOT_LOADER_TIMEOUT_EN and TIMEOUT_CYC=16: stall 16 cycles after byte 3 of the payload → error=1; a stall of 15 cycles → the load completes normally.
